reg_bank_seq: RTL and testbench
===============================

# reg_bank_seq

Parametrised successor to the single opcode register: a sequenced, double-buffered bank of `NUM_CH` registers, each `WIDTH` bits, loaded from one shared data bus. Each rising edge of `load` captures `d` into the next staging slot. Once every slot is filled, the whole set is committed atomically to the output registers. It sits between the debounced switch/button front end and the ALU, so the ALU never sees a half-updated set of operands and opcode (e.g. A, B, OP).

## Interface
- `WIDTH`, default 8: bits per channel.
- `NUM_CH`, default 3: number of channels; must be ≥ 2.
- `CW`, derived as `$clog2(NUM_CH)`: pointer width. It is a localparam, not user-settable.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `d`  in  WIDTH  data to capture; already synchronous to `clk`.
- `load`  in  1  level-sensitive capture request; the block detects its rising edge internally.
- `clear`  in  1  synchronous abort of a partial fill.
- `q`  out  NUM_CH*WIDTH  committed bank; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `ch_idx`  out  CW  index of the next slot to be filled.
- `busy`  out  1  high while at least one slot is staged and not yet committed.
- `valid`  out  1  one-cycle pulse when `q` has just been updated.
- `rd_sel`  in  CW  staging readback select; present only with `REG_BANK_READBACK_EN`.
- `rd_data`  out  WIDTH  staging readback data; present only with `REG_BANK_READBACK_EN`.

## Operation
- Edge detect:
  - `load_q` registers `load`.
  - `ld_edge = load & ~load_q`.
  - `load_q` resets to 1, so a `load` held high through reset release does not produce a capture.
- State machine, three states:
  - IDLE: `ptr` = 0. On `ld_edge`: `stage[0] <= d`, `ptr <= 1`, go to FILL.
  - FILL: on `ld_edge`: `stage[ptr] <= d`. If `ptr == NUM_CH-1`, go to COMMIT and set `ptr <= 0`; otherwise `ptr <= ptr+1`.
  - COMMIT: lasts exactly one cycle. `q <= stage` (all channels at once), `valid <= 1`, go to IDLE. Any `ld_edge` arriving during COMMIT is ignored.
- `clear` priority:
  - `clear` beats `load`.
  - In FILL or COMMIT, `clear` sends the FSM to IDLE with `ptr` = 0.
  - Staging contents are left stale, `q` is unchanged and `valid` stays low. A clear in COMMIT aborts the commit.
  - In IDLE, `clear` has no effect.
- Outputs:
  - `busy` = (state == FILL) | (state == COMMIT).
  - `ch_idx` = `ptr`.
  - `q` changes only in COMMIT.
- Reset values: `q` = 0, `stage` = 0, `ptr` = 0, state IDLE, `valid` = 0, `busy` = 0, `ch_idx` = 0, `load_q` = 1.
- Asserting `rst_n` low mid-fill clears everything immediately, with no clock needed.

## Timing
- Capture latency: `d` is sampled on the clock edge where `ld_edge` = 1, giving one capture per `load` pulse regardless of pulse length.
- Commit latency:
  - Last capture at clock edge k.
  - `q` updated and `valid` high after edge k+1.
  - `valid` returns low after edge k+2.
- Minimum spacing between `load` rising edges is 2 cycles (high, then low).
- Back-to-back sets: the first capture of the next set may occur at edge k+2 or later.

## Configuration
- `REG_BANK_READBACK_EN` defined:
  - adds `rd_sel` and `rd_data`;
  - `rd_data` = `stage[rd_sel]`, combinational, for displaying partial entries on LEDs;
  - an out-of-range `rd_sel` returns 0.
- `REG_BANK_READBACK_EN` undefined: both ports and the readback mux are absent. All other behaviour is identical.

## Structure
- Package `reg_bank_pkg` holds:
  - the state enum (IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2);
  - the minimum-channel constant `REG_BANK_MIN_CH = 2`.
- Sub-module `edge_rise`:
  - ports `clk`, `rst_n`, `in`, `pulse`;
  - takes a reset value for its internal register as a parameter, set to 1 here;
  - reusable for the button inputs elsewhere in the design.

## Test plan
All scenarios use WIDTH=8, NUM_CH=3.
- Reset release with `load` held high → no capture; `ch_idx`=0, `busy`=0, `q`=0.
- Load 0x12, 0x34, 0x05 with 2-cycle pulses → `q`=0x053412 one cycle after the third edge; `valid` is a single-cycle pulse; `busy` falls with it.
- Load 0xAA, 0xBB, then `clear` → `q` keeps its previous value, `ch_idx`=0, no `valid`. The next set 0x01, 0x02, 0x03 gives `q`=0x030201.
- `load` held high for 10 cycles → exactly one capture; `ch_idx` goes 0→1.
- Drive `rst_n` low mid-fill, asynchronously between clock edges → all outputs 0 immediately. Then a full load of 0xFF, 0x00, 0x7F gives `q`=0x7F00FF.
- With `REG_BANK_READBACK_EN` defined, after loading 0x9C into slot 0 → `rd_sel`=0 gives `rd_data`=0x9C, while `q` is still 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and constants for the sequenced, double-buffered register bank.
//   state_t          : fill/commit state machine encoding
//   REG_BANK_MIN_CH  : smallest channel count the bank supports
// No ports; imported by reg_bank_seq.
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int REG_BANK_MIN_CH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_seq_edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Single-cycle rising-edge detector for a signal already synchronous to clk.
// Reusable for button inputs; RESET_VAL chooses what the previous-sample
// register holds after reset, so an input held high through reset release can
// be made to produce no pulse (RESET_VAL = 1).
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   in     in  1  level input
//   pulse  out 1  high for the cycle where in is high and was low last cycle
// -----------------------------------------------------------------------------
module edge_rise #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= RESET_VAL;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/reg_bank_seq.sv
// -----------------------------------------------------------------------------
// reg_bank_seq
// Sequenced, double-buffered bank of NUM_CH registers of WIDTH bits, loaded one
// slot per rising edge of load from the shared bus d. When the last slot is
// filled the whole staging set is copied to q in a single cycle, so downstream
// logic never sees a partially updated set.
//
// Optional feature macro: REG_BANK_READBACK_EN
//   When defined, adds rd_sel/rd_data for combinational readback of the staging
//   registers (out-of-range rd_sel reads 0).
//
// Ports:
//   clk     in  1             clock, rising edge
//   rst_n   in  1             asynchronous active-low reset
//   d       in  WIDTH         data captured on a load rising edge
//   load    in  1             level capture request (edge detected inside)
//   clear   in  1             synchronous abort of a partial fill / pending commit
//   q       out NUM_CH*WIDTH  committed bank, channel i at [i*WIDTH +: WIDTH]
//   ch_idx  out CW            next slot to be filled
//   busy    out 1             a set is partially staged or committing
//   valid   out 1             one-cycle pulse after q updates
//   rd_sel  in  CW            staging readback select (REG_BANK_READBACK_EN)
//   rd_data out WIDTH         staging readback data   (REG_BANK_READBACK_EN)
// -----------------------------------------------------------------------------
module reg_bank_seq
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 3,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        d,
    input  logic                    load,
    input  logic                    clear,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [CW-1:0]           ch_idx,
    output logic                    busy,
    output logic                    valid
`ifdef REG_BANK_READBACK_EN
    ,
    input  logic [CW-1:0]           rd_sel,
    output logic [WIDTH-1:0]        rd_data
`endif
);

    generate
        if (NUM_CH < REG_BANK_MIN_CH) begin : g_bad_num_ch
            $error("reg_bank_seq: NUM_CH must be at least %0d", REG_BANK_MIN_CH);
        end
    endgenerate

    localparam logic [CW-1:0] LAST_PTR = CW'(NUM_CH - 1);

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     ptr_next;
    logic              ld_edge;
    logic              stage_we;
    logic              commit;
    logic [WIDTH-1:0]  stage [NUM_CH];

    // Previous-load register resets high so a load held through reset release
    // is not mistaken for a fresh request.
    edge_rise #(
        .RESET_VAL (1'b1)
    ) u_load_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (load),
        .pulse (ld_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= ptr_next;
        end
    end

    // clear takes precedence over a simultaneous load edge everywhere; in IDLE
    // there is nothing to abort, it only suppresses the capture. A load edge in
    // COMMIT is dropped because the set is already complete.
    always_comb begin
        next_state = state;
        ptr_next   = ptr;
        stage_we   = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (!clear && ld_edge) begin
                    stage_we   = 1'b1;
                    ptr_next   = CW'(1);
                    next_state = FILL;
                end
            end
            FILL: begin
                if (clear) begin
                    ptr_next   = '0;
                    next_state = IDLE;
                end else if (ld_edge) begin
                    stage_we = 1'b1;
                    if (ptr == LAST_PTR) begin
                        ptr_next   = '0;
                        next_state = COMMIT;
                    end else begin
                        ptr_next = ptr + CW'(1);
                    end
                end
            end
            COMMIT: begin
                ptr_next   = '0;
                next_state = IDLE;
                commit     = !clear;
            end
            default: begin
                ptr_next   = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Staging slots, committed bank and the valid pulse. Staging is never
    // cleared by clear; stale contents are simply overwritten by the next set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stage[i] <= '0;
            end
            q     <= '0;
            valid <= 1'b0;
        end else begin
            if (stage_we) begin
                stage[ptr] <= d;
            end
            if (commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    q[i*WIDTH +: WIDTH] <= stage[i];
                end
            end
            valid <= commit;
        end
    end

    assign busy   = (state == FILL) || (state == COMMIT);
    assign ch_idx = ptr;

`ifdef REG_BANK_READBACK_EN
    always_comb begin
        rd_data = '0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_data = stage[rd_sel];
        end
    end
`endif

endmodule

// File: tb/tb_reg_bank_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_seq
// Directed testbench for reg_bank_seq with WIDTH=8, NUM_CH=3. Inputs change
// 1 time unit after each rising edge; outputs are sampled at the same point.
// Readback scenario is included only when REG_BANK_READBACK_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_bank_seq;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 3;
    localparam int CW     = $clog2(NUM_CH);

    logic                    clk;
    logic                    rst_n;
    logic [WIDTH-1:0]        d;
    logic                    load;
    logic                    clear;
    logic [NUM_CH*WIDTH-1:0] q;
    logic [CW-1:0]           ch_idx;
    logic                    busy;
    logic                    valid;
`ifdef REG_BANK_READBACK_EN
    logic [CW-1:0]           rd_sel;
    logic [WIDTH-1:0]        rd_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    reg_bank_seq #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .load   (load),
        .clear  (clear),
        .q      (q),
        .ch_idx (ch_idx),
        .busy   (busy),
        .valid  (valid)
`ifdef REG_BANK_READBACK_EN
        ,
        .rd_sel (rd_sel),
        .rd_data(rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise load with data for one edge and leave load low afterwards.
    task automatic press(input logic [WIDTH-1:0] data);
        d    = data;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // A complete two-cycle load pulse (high one edge, low one edge).
    task automatic pulse_load(input logic [WIDTH-1:0] data);
        press(data);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        clear = 1'b0;
        d     = 8'h5A;
        #23;
        n_checks++; if (q !== 24'h0) $display("[TB] FAIL reset_q: got %h expected %h", q, 24'h0); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++; if (ch_idx !== 2'd0) $display("[TB] FAIL reset_held_load_ch_idx: got %0d expected 0", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_held_load_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (q !== 24'h0) $display("[TB] FAIL reset_held_load_q: got %h expected %h", q, 24'h0); else n_pass++;
        load = 1'b0;
        tick();
    endtask

    task automatic test_basic_fill();
        pulse_load(8'h12);
        n_checks++; if (ch_idx !== 2'd1) $display("[TB] FAIL fill1_ch_idx: got %0d expected 1", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL fill1_busy: got %b expected 1", busy); else n_pass++;
        pulse_load(8'h34);
        n_checks++; if (ch_idx !== 2'd2) $display("[TB] FAIL fill2_ch_idx: got %0d expected 2", ch_idx); else n_pass++;
        press(8'h05);
        n_checks++; if (ch_idx !== 2'd0) $display("[TB] FAIL last_ch_idx: got %0d expected 0", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL commit_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (q !== 24'h0) $display("[TB] FAIL commit_q_early: got %h expected %h", q, 24'h0); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL commit_valid_early: got %b expected 0", valid); else n_pass++;
        tick();
        n_checks++; if (q !== 24'h053412) $display("[TB] FAIL basic_q: got %h expected %h", q, 24'h053412); else n_pass++;
        n_checks++; if (valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_fall: got %b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL basic_valid_pulse: got %b expected 0", valid); else n_pass++;
        n_checks++; if (q !== 24'h053412) $display("[TB] FAIL basic_q_hold: got %h expected %h", q, 24'h053412); else n_pass++;
    endtask

    task automatic test_clear();
        pulse_load(8'hAA);
        pulse_load(8'hBB);
        n_checks++; if (ch_idx !== 2'd2) $display("[TB] FAIL clear_pre_ch_idx: got %0d expected 2", ch_idx); else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (ch_idx !== 2'd0) $display("[TB] FAIL clear_ch_idx: got %0d expected 0", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL clear_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (q !== 24'h053412) $display("[TB] FAIL clear_q: got %h expected %h", q, 24'h053412); else n_pass++;
        tick();
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL clear_valid: got %b expected 0", valid); else n_pass++;
        pulse_load(8'h01);
        pulse_load(8'h02);
        press(8'h03);
        tick();
        n_checks++; if (q !== 24'h030201) $display("[TB] FAIL after_clear_q: got %h expected %h", q, 24'h030201); else n_pass++;
        n_checks++; if (valid !== 1'b1) $display("[TB] FAIL after_clear_valid: got %b expected 1", valid); else n_pass++;
        tick();
        // Clear arriving in the commit cycle aborts the commit.
        pulse_load(8'h11);
        pulse_load(8'h22);
        press(8'h33);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (q !== 24'h030201) $display("[TB] FAIL commit_abort_q: got %h expected %h", q, 24'h030201); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL commit_abort_valid: got %b expected 0", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL commit_abort_busy: got %b expected 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_long_load();
        d    = 8'h44;
        load = 1'b1;
        tick();
        n_checks++; if (ch_idx !== 2'd1) $display("[TB] FAIL long_first_ch_idx: got %0d expected 1", ch_idx); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            d = 8'(8'h60 + i);
            tick();
        end
        n_checks++; if (ch_idx !== 2'd1) $display("[TB] FAIL long_held_ch_idx: got %0d expected 1", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL long_held_busy: got %b expected 1", busy); else n_pass++;
        load = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (ch_idx !== 2'd0) $display("[TB] FAIL long_clear_ch_idx: got %0d expected 0", ch_idx); else n_pass++;
    endtask

    task automatic test_back_to_back();
        pulse_load(8'h0A);
        pulse_load(8'h0B);
        press(8'h0C);
        tick();
        n_checks++; if (q !== 24'h0C0B0A) $display("[TB] FAIL b2b_first_q: got %h expected %h", q, 24'h0C0B0A); else n_pass++;
        press(8'h0D);
        n_checks++; if (ch_idx !== 2'd1) $display("[TB] FAIL b2b_next_ch_idx: got %0d expected 1", ch_idx); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL b2b_valid_low: got %b expected 0", valid); else n_pass++;
        tick();
        pulse_load(8'h0E);
        press(8'h0F);
        tick();
        n_checks++; if (q !== 24'h0F0E0D) $display("[TB] FAIL b2b_second_q: got %h expected %h", q, 24'h0F0E0D); else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        pulse_load(8'h55);
        n_checks++; if (ch_idx !== 2'd1) $display("[TB] FAIL arst_pre_ch_idx: got %0d expected 1", ch_idx); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (q !== 24'h0) $display("[TB] FAIL arst_q: got %h expected %h", q, 24'h0); else n_pass++;
        n_checks++; if (ch_idx !== 2'd0) $display("[TB] FAIL arst_ch_idx: got %0d expected 0", ch_idx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL arst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("[TB] FAIL arst_valid: got %b expected 0", valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_load(8'hFF);
        pulse_load(8'h00);
        press(8'h7F);
        tick();
        n_checks++; if (q !== 24'h7F00FF) $display("[TB] FAIL arst_reload_q: got %h expected %h", q, 24'h7F00FF); else n_pass++;
        n_checks++; if (valid !== 1'b1) $display("[TB] FAIL arst_reload_valid: got %b expected 1", valid); else n_pass++;
        tick();
    endtask

`ifdef REG_BANK_READBACK_EN
    task automatic test_readback();
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        pulse_load(8'h9C);
        rd_sel = 2'd0;
        #1;
        n_checks++; if (rd_data !== 8'h9C) $display("[TB] FAIL readback_slot0: got %h expected %h", rd_data, 8'h9C); else n_pass++;
        n_checks++; if (q !== 24'h0) $display("[TB] FAIL readback_q: got %h expected %h", q, 24'h0); else n_pass++;
        rd_sel = 2'd3;
        #1;
        n_checks++; if (rd_data !== 8'h00) $display("[TB] FAIL readback_out_of_range: got %h expected %h", rd_data, 8'h00); else n_pass++;
        rd_sel = 2'd0;
    endtask
`endif

    initial begin
        d     = '0;
        load  = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
`ifdef REG_BANK_READBACK_EN
        rd_sel = '0;
`endif
        test_reset();
        test_basic_fill();
        test_clear();
        test_long_load();
        test_back_to_back();
        test_async_reset();
`ifdef REG_BANK_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
